// File: rtl/nor3_sweep_ctrl.sv
// Clocked sweep sequencer for a bank of 3-input NOR gates: drives all 8 input vectors,
// waits SETTLE cycles, then checks every gate output and accumulates error statistics.
module nor3_sweep_ctrl #(
  parameter int N_GATES = 5,
  parameter int SETTLE  = 2,
  parameter int LOOPS   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [N_GATES-1:0] gate_out,
  output logic               in1,
  output logic               in2,
  output logic               in3,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [7:0]         err_count,
  output logic [N_GATES-1:0] fail_mask,
  output logic [2:0]         first_fail_vec
);

  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_WAIT, S_CHECK, S_DONE} state_t;

  localparam logic [7:0] SETTLE_C = 8'(SETTLE);
  localparam logic [7:0] LOOPS_M1 = 8'(LOOPS - 1);

  state_t             state_q, state_d;
  logic [2:0]         vec_q, vec_d;
  logic [7:0]         loop_q, loop_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         err_q, err_d;
  logic [N_GATES-1:0] mask_q, mask_d;
  logic [2:0]         ffv_q, ffv_d;
  logic               pass_q, pass_d;
  logic               exp_bit;
  logic [N_GATES-1:0] mis;

  // Case inequality so an X/Z on a gate output is reported as a mismatch in simulation.
  always_comb begin
    exp_bit = (vec_q == 3'd0);
    for (int i = 0; i < N_GATES; i++) begin
      mis[i] = (gate_out[i] !== exp_bit);
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    loop_d  = loop_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    mask_d  = mask_q;
    ffv_d   = ffv_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (abort) begin
          vec_d = 3'd0;
        end else if (start) begin
          state_d = S_APPLY;
          vec_d   = 3'd0;
          loop_d  = 8'd0;
          cnt_d   = SETTLE_C;
          err_d   = 8'd0;
          mask_d  = '0;
          ffv_d   = 3'd0;
          pass_d  = 1'b0;
        end
      end
      S_APPLY: state_d = (SETTLE > 0) ? S_WAIT : S_CHECK;
      S_WAIT: begin
        if (cnt_q <= 8'd1) state_d = S_CHECK;
        else cnt_d = cnt_q - 8'd1;
      end
      S_CHECK: begin
        if (mis != '0) begin
          mask_d = mask_q | mis;
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          if (err_q == 8'd0) ffv_d = vec_q;
        end
        if (vec_q != 3'd7) begin
          vec_d   = vec_q + 3'd1;
          cnt_d   = SETTLE_C;
          state_d = S_APPLY;
        end else if (loop_q < LOOPS_M1) begin
          vec_d   = 3'd0;
          loop_d  = loop_q + 8'd1;
          cnt_d   = SETTLE_C;
          state_d = S_APPLY;
        end else begin
          state_d = S_DONE;
          pass_d  = (err_d == 8'd0);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (abort) vec_d = 3'd0;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort keeps the partial statistics but discards any update from this cycle.
    if (abort && (state_q == S_APPLY || state_q == S_WAIT || state_q == S_CHECK)) begin
      state_d = S_IDLE;
      vec_d   = 3'd0;
      pass_d  = 1'b0;
      err_d   = err_q;
      mask_d  = mask_q;
      ffv_d   = ffv_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= 3'd0;
      loop_q  <= 8'd0;
      cnt_q   <= 8'd0;
      err_q   <= 8'd0;
      mask_q  <= '0;
      ffv_q   <= 3'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      loop_q  <= loop_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      ffv_q   <= ffv_d;
      pass_q  <= pass_d;
    end
  end

  assign in1            = vec_q[0];
  assign in2            = vec_q[1];
  assign in3            = vec_q[2];
  assign busy           = (state_q == S_APPLY) || (state_q == S_WAIT) || (state_q == S_CHECK);
  assign done           = (state_q == S_DONE);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign fail_mask      = mask_q;
  assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_nor3_sweep_ctrl.sv
// Bench for nor3_sweep_ctrl: three instances (default, SETTLE=0, LOOPS=40) with modelled
// gate banks; run results are queued at start and checked on each done pulse.
module tb_nor3_sweep_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_n, start, abort, start_b, start_c, abort_b, abort_c;
  logic [4:0] gate_out, gate_out_b, gate_out_c;
  logic       in1, in2, in3, busy, done, pass;
  logic [7:0] err_count;
  logic [4:0] fail_mask;
  logic [2:0] ffv;
  logic       in1_b, in2_b, in3_b, busy_b, done_b, pass_b;
  logic [7:0] err_b;
  logic [4:0] mask_b;
  logic [2:0] ffv_b;
  logic       in1_c, in2_c, in3_c, busy_c, done_c, pass_c;
  logic [7:0] err_c;
  logic [4:0] mask_c;
  logic [2:0] ffv_c;

  int mode [5];  // 0 ideal NOR, 1 stuck-at-0, 2 stuck-at-1

  always_comb begin
    gate_out = '0;
    for (int i = 0; i < 5; i++) begin
      if (mode[i] == 1)      gate_out[i] = 1'b0;
      else if (mode[i] == 2) gate_out[i] = 1'b1;
      else                   gate_out[i] = ~(in1 | in2 | in3);
    end
  end
  assign gate_out_b = {5{~(in1_b | in2_b | in3_b)}};
  assign gate_out_c = 5'b11111;

  nor3_sweep_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_out(gate_out),
    .in1(in1), .in2(in2), .in3(in3), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_mask(fail_mask), .first_fail_vec(ffv));

  nor3_sweep_ctrl #(.N_GATES(5), .SETTLE(0), .LOOPS(1)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .gate_out(gate_out_b),
    .in1(in1_b), .in2(in2_b), .in3(in3_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .fail_mask(mask_b), .first_fail_vec(ffv_b));

  nor3_sweep_ctrl #(.N_GATES(5), .SETTLE(2), .LOOPS(40)) u_l40 (
    .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_c), .gate_out(gate_out_c),
    .in1(in1_c), .in2(in2_c), .in3(in3_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .err_count(err_c), .fail_mask(mask_c), .first_fail_vec(ffv_c));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic       pass;
    logic [7:0] err;
    logic [4:0] mask;
    logic [2:0] ffv;
    int         lat;
    int         k;
  } exp_t;

  exp_t q_a[$], q_b[$], q_c[$];

  task automatic check_done(input string tag, input exp_t e, input logic p, input logic b,
                            input logic [7:0] ec, input logic [4:0] fm, input logic [2:0] fv);
    chk({tag, "_pass"},    32'(p),  32'(e.pass));
    chk({tag, "_busy"},    32'(b),  32'd0);
    chk({tag, "_errcnt"},  32'(ec), 32'(e.err));
    chk({tag, "_mask"},    32'(fm), 32'(e.mask));
    chk({tag, "_ffv"},     32'(fv), 32'(e.ffv));
    chk({tag, "_latency"}, 32'(cyc - e.k), 32'(e.lat));
  endtask

  always @(negedge clk) if (done === 1'b1) begin
    if (q_a.size() == 0) chk("a_spurious_done", 32'(done), 32'd0);
    else check_done("a", q_a.pop_front(), pass, busy, err_count, fail_mask, ffv);
  end
  always @(negedge clk) if (done_b === 1'b1) begin
    if (q_b.size() == 0) chk("b_spurious_done", 32'(done_b), 32'd0);
    else check_done("b", q_b.pop_front(), pass_b, busy_b, err_b, mask_b, ffv_b);
  end
  always @(negedge clk) if (done_c === 1'b1) begin
    if (q_c.size() == 0) chk("c_spurious_done", 32'(done_c), 32'd0);
    else check_done("c", q_c.pop_front(), pass_c, busy_c, err_c, mask_c, ffv_c);
  end

  task automatic pulse_start(input int which, output int k);
    @(negedge clk);
    case (which)
      0:       start   = 1'b1;
      1:       start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    @(posedge clk);
    #1;
    k       = cyc;
    start   = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  task automatic push_a(input logic p, input logic [7:0] e, input logic [4:0] m,
                        input logic [2:0] f, input int lat, input int k);
    exp_t x;
    x.pass = p; x.err = e; x.mask = m; x.ffv = f; x.lat = lat; x.k = k;
    q_a.push_back(x);
  endtask

  task automatic set_all_ideal();
    for (int i = 0; i < 5; i++) mode[i] = 0;
  endtask

  initial begin
    int   k;
    exp_t x;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    start_b = 1'b0; start_c = 1'b0; abort_b = 1'b0; abort_c = 1'b0;
    set_all_ideal();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_err", 32'(err_count), 0);
    chk("rst_mask", 32'(fail_mask), 0);
    chk("rst_ffv", 32'(ffv), 0);
    chk("rst_vec", 32'({in3, in2, in1}), 0);
    rst_n = 1'b1;

    // Ideal gates: vector sequence held 4 cycles each, then start in DONE is ignored
    pulse_start(0, k);
    push_a(1'b1, 8'd0, 5'b00000, 3'b000, 32, k);
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      chk("t1_vec", 32'({in3, in2, in1}), 32'(j / 4));
      chk("t1_busy", 32'(busy), 1);
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t1_start_in_done_ignored", 32'(busy), 0);
    repeat (2) @(negedge clk);

    mode[3] = 1;
    pulse_start(0, k);
    push_a(1'b0, 8'd1, 5'b01000, 3'b000, 32, k);
    repeat (34) @(negedge clk);
    set_all_ideal();

    mode[0] = 2;
    pulse_start(0, k);
    push_a(1'b0, 8'd7, 5'b00001, 3'b001, 32, k);
    repeat (34) @(negedge clk);

    // Abort at cycle 10, with a mid-run start that must not restart the sweep
    pulse_start(0, k);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (j == 4) start = 1'b1;
      if (j == 5) start = 1'b0;
      if (j == 9) begin
        chk("ab_no_restart_vec", 32'({in3, in2, in1}), 2);
        chk("ab_partial_err", 32'(err_count), 1);
        abort = 1'b1;
      end
    end
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 0);
    chk("ab_vec", 32'({in3, in2, in1}), 0);
    chk("ab_done", 32'(done), 0);
    chk("ab_pass", 32'(pass), 0);
    chk("ab_err_hold", 32'(err_count), 1);
    chk("ab_mask_hold", 32'(fail_mask), 32'h01);
    chk("ab_ffv_hold", 32'(ffv), 1);
    repeat (40) @(negedge clk);
    chk("ab_still_idle", 32'(busy), 0);
    set_all_ideal();

    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", 32'(busy), 0);

    // Reset in the WAIT of vector 1, after the vector-0 error has been counted
    mode[3] = 1;
    pulse_start(0, k);
    repeat (6) @(negedge clk);
    chk("rw_pre_err", 32'(err_count), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rw_busy", 32'(busy), 0);
    chk("rw_done", 32'(done), 0);
    chk("rw_pass", 32'(pass), 0);
    chk("rw_err", 32'(err_count), 0);
    chk("rw_mask", 32'(fail_mask), 0);
    chk("rw_ffv", 32'(ffv), 0);
    chk("rw_vec", 32'({in3, in2, in1}), 0);
    set_all_ideal();
    pulse_start(0, k);
    push_a(1'b1, 8'd0, 5'b00000, 3'b000, 32, k);
    repeat (34) @(negedge clk);

    pulse_start(1, k);
    x.pass = 1'b1; x.err = 8'd0; x.mask = 5'b00000; x.ffv = 3'b000; x.lat = 16; x.k = k;
    q_b.push_back(x);
    repeat (18) @(negedge clk);

    pulse_start(2, k);
    x.pass = 1'b0; x.err = 8'd255; x.mask = 5'b11111; x.ffv = 3'b001; x.lat = 1280; x.k = k;
    q_c.push_back(x);
    repeat (1282) @(negedge clk);

    for (int t = 0; t < 100 && (q_a.size() + q_b.size() + q_c.size()) != 0; t++) @(negedge clk);
    chk("pending_results", 32'(q_a.size() + q_b.size() + q_c.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/nor3_sweep_ctrl.md
Name: nor3_sweep_ctrl

Overview:
- Sequencer for a bank of N_GATES parallel nor3NMOS instances whose inputs in1/in2/in3 are all tied to this block's outputs.
- On start, applies all 8 input combinations LOOPS times, waits a programmable settle time per vector, then samples every gate output against the expected 3-input NOR.
- Reports a saturating error count, a per-gate failure mask, the first failing vector and a pass flag.
- Sits between the stimulus/test host and the switch-level gate bank. It replaces free-running toggle stimulus with a deterministic, clocked sweep.

Parameters:
- N_GATES, 5, number of gate instances sampled in parallel (1..32).
- SETTLE, 2, wait cycles between applying a vector and sampling (0..255; 0 means no WAIT state).
- LOOPS, 1, number of full 8-vector passes per run (1..255).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  run request; sampled only in IDLE.
- abort  in  1  cancel the current run; takes effect next edge.
- gate_out  in  N_GATES  outputs of gate instances, bit i = instance i.
- in1  out  1  gate input 1 = vec[0].
- in2  out  1  gate input 2 = vec[1].
- in3  out  1  gate input 3 = vec[2].
- busy  out  1  high while a run is active (APPLY/WAIT/CHECK).
- done  out  1  one-cycle pulse on normal run completion.
- pass  out  1  high after a completed run with zero errors; held until next start.
- err_count  out  8  number of CHECK cycles with any mismatch, saturates at 255.
- fail_mask  out  N_GATES  sticky; bit i set if gate i ever mismatched during the run.
- first_fail_vec  out  3  {in3,in2,in1} of the first failing CHECK; valid when err_count!=0.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; in1/in2/in3=0; busy=0, done=0, pass=0, err_count=0, fail_mask=0, first_fail_vec=0. Reset dominates start and abort and aborts any run in progress.
- FSM states: IDLE, APPLY, WAIT, CHECK, DONE.
- IDLE: start=1 and abort=0 at the edge leads to APPLY, with the following at the same edge:
  - vec=0, loop=0;
  - err_count, fail_mask, first_fail_vec, pass cleared;
  - busy=1.
- APPLY, 1 cycle: outputs already show vec. Goes to WAIT if SETTLE>0, else to CHECK.
- WAIT, exactly SETTLE cycles: a down-counter loaded on APPLY entry. Goes to CHECK when it reaches zero.
- CHECK, 1 cycle:
  - Expected value exp = ~(vec[0]|vec[1]|vec[2]), i.e. 1 only for vec=0.
  - Per-gate mismatch m[i] = (gate_out[i] !== exp). X or Z counts as a mismatch.
  - If m != 0: fail_mask |= m; err_count increments unless it is already 255; first_fail_vec = vec if err_count was 0.
  - Next state:
    - vec<7: vec+1, go to APPLY.
    - vec==7 and loop<LOOPS-1: vec wraps to 0, loop+1, go to APPLY.
    - otherwise: go to DONE.
- DONE, 1 cycle: done=1, busy=0, pass=(err_count==0). Then IDLE.
- in1/in2/in3 are registered from vec, change only on APPLY entry, and are held through WAIT/CHECK.
- In IDLE and DONE, in1/in2/in3 keep the last applied vector. After reset or abort they are 0.
- Latency: with start accepted at edge k, done is high in the cycle after edge k + 8·LOOPS·(SETTLE+2). For defaults this is 32 cycles. busy is high from k to that same edge.
- start while busy is ignored and does not restart the run. start in the DONE cycle is ignored.
- abort while busy:
  - next edge goes to IDLE; in1/in2/in3=0; busy=0; no done pulse; pass=0;
  - err_count, fail_mask and first_fail_vec hold their partial values.
- abort and start in the same IDLE cycle: abort wins and no run starts.
- abort in IDLE has no effect, apart from forcing in1/in2/in3=0.

Test Plan:
- All gates model ideal NOR, defaults, start pulse at edge k -> in sequence 000..111, each held 4 cycles; done pulse after edge k+32; pass=1, err_count=0, fail_mask=0.
- Gate 3 stuck-at-0 -> err_count=1, fail_mask=5'b01000, first_fail_vec=3'b000, pass=0.
- Gate 0 stuck-at-1 -> err_count=7, fail_mask=5'b00001, first_fail_vec=3'b001, pass=0.
- LOOPS=40, all gates stuck-at-1 -> 280 failing checks, err_count saturates at 255, fail_mask=5'b11111, done after 40·8·4 = 1280 cycles.
- abort at cycle 10 of a run -> IDLE next edge, busy=0, in1..in3=0, no done; a start pulse during the run before the abort does not restart it.
- rst_n=0 for one edge mid-WAIT -> all outputs at reset values; a new start then produces a full, correct 32-cycle run; SETTLE=0 variant gives done at k+16.
